rf8_onehot_wr: RTL and testbench
================================

Name: rf8_onehot_wr

Overview:
8-entry register file for the processor datapath. It sits directly downstream of the 3-to-8 write-register decoder and takes that decoder's one-hot outputs as per-register write enables. It provides two combinational read ports with optional write-to-read bypass, and flags illegal (multi-hot) write selects.

Parameters:
WIDTH, 16, data width of each register and of the read/write data ports
BYPASS, 1, 1 = a same-cycle write is forwarded to matching read ports; 0 = reads return the stored value only

Ports:
clk  input  1  system clock, rising-edge active
rst_n  input  1  asynchronous active-low reset
wr_sel  input  8  one-hot write enables; bit i selects register i; all-zero means no write
wr_data  input  WIDTH  write data
rd_addr1  input  3  read port 1 register index
rd_addr2  input  3  read port 2 register index
rd_data1  output  WIDTH  read port 1 data (combinational)
rd_data2  output  WIDTH  read port 2 data (combinational)
err  output  1  registered; pulses high one cycle after an illegal wr_sel
err_sticky  output  1  registered; set by any illegal wr_sel, cleared only by reset

Behaviour:
- One clock (clk); reset is asynchronous and active-low (rst_n). All state resets immediately on rst_n low, independent of clk.
- Reset values:
  - all 8 registers = 0; err = 0; err_sticky = 0.
  - rd_data1/rd_data2 therefore read 0 while reset is asserted. If BYPASS=1 and wr_sel is legal during reset, rd_data returns the bypassed wr_data.
- Legality of wr_sel (combinational):
  - zero bits set = idle, legal.
  - exactly one bit set = write, legal.
  - two or more bits set = illegal.
- Write timing:
  - On a rising clk edge with rst_n high and exactly one wr_sel bit i set, register i <= wr_data.
  - The new value is visible on read ports from the following cycle (1-cycle write latency).
- Illegal select:
  - No register is written; all registers hold.
  - err = 1 for exactly the next cycle; it returns to 0 if the following wr_sel is legal.
  - err_sticky = 1 and holds until reset.
  - Back-to-back illegal cycles keep err high continuously.
- Reads:
  - rd_dataN = reg[rd_addrN], purely combinational, zero clock latency.
  - No register is hardwired to zero; register 0 is writable.
- Bypass (BYPASS=1):
  - If wr_sel is legal, non-zero, and has bit rd_addrN set in the same cycle, rd_dataN = wr_data.
  - Both ports may bypass simultaneously, including when rd_addr1 == rd_addr2.
  - An illegal wr_sel never bypasses; reads return stored values.
- BYPASS=0: reads never see in-flight write data.
- Reset mid-operation: rst_n falling in the same cycle as a write aborts the write. All registers read 0 once rst_n is low.
- Only the data bus width scales with WIDTH; register count is fixed at 8 with 3-bit addresses.

Decomposition:
- Shared package (proc_pkg):
  - constants NREGS = 8, RADDR_W = 3, default DATA_W = 16.
  - function onehot0_chk(8-bit) returning {legal, nonzero}, reusable by other decoder consumers.
- Natural sub-module: rf_reg_en, a single WIDTH-bit register with enable and async active-low reset. It is instantiated 8 times, with enable = wr_sel[i] & legal.
- Read muxes and bypass logic stay in the top.

Test Plan:
- Reset: drive rst_n=0 mid-simulation after writing 0xBEEF to r3 -> rd_data1 (addr 3) reads 0x0000 immediately, without waiting for a clk edge; err=0, err_sticky=0.
- Single write/read: wr_sel=8'b0010_0000, wr_data=0x1234, rd_addr1=5, BYPASS=0 -> rd_data1 reads the old value this cycle and 0x1234 the next cycle; all other registers are unchanged.
- Bypass: BYPASS=1, r2=0x00AA, wr_sel=8'b0000_0100, wr_data=0x5555, rd_addr1=rd_addr2=2 -> both ports read 0x5555 in the same cycle; r2=0x5555 afterwards.
- Illegal select: wr_sel=8'b1000_0001, wr_data=0xFFFF -> r0 and r7 are unchanged; no bypass; err=1 for one cycle then 0; err_sticky=1 and stays set through 10 further legal cycles until rst_n pulses.
- Idle and full sweep: write r0..r7 with 0x1000+i using the one-hot selects in sequence, then wr_sel=0 for 3 cycles -> every rd_addr returns 0x1000+i on both ports and nothing changes during the idle cycles.

Source files
------------

// File: rtl/rf8_onehot_wr_pkg.sv
// proc_pkg: shared register-file constants and one-hot select checker
package proc_pkg;
  localparam int NREGS   = 8;
  localparam int RADDR_W = 3;
  localparam int DATA_W  = 16;
  // returns {legal, nonzero}; legal means at most one bit set
  function automatic logic [1:0] onehot0_chk(input logic [NREGS-1:0] v);
    return {((v & (v - 8'd1)) == '0), |v};
  endfunction
endpackage

// File: rtl/rf8_onehot_wr_reg_en.sv
// rf_reg_en: WIDTH-bit register with load enable and async active-low reset
module rf_reg_en #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  logic [WIDTH-1:0] data_d, data_q;
  always_comb data_d = en ? d : data_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) data_q <= '0;
    else        data_q <= data_d;
  assign q = data_q;
endmodule

// File: rtl/rf8_onehot_wr.sv
// rf8_onehot_wr: 8-entry register file written by one-hot selects, two
// combinational read ports with optional write bypass and illegal-select flags
module rf8_onehot_wr
  import proc_pkg::*;
#(
  parameter int WIDTH  = DATA_W,
  parameter int BYPASS = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NREGS-1:0]   wr_sel,
  input  logic [WIDTH-1:0]   wr_data,
  input  logic [RADDR_W-1:0] rd_addr1,
  input  logic [RADDR_W-1:0] rd_addr2,
  output logic [WIDTH-1:0]   rd_data1,
  output logic [WIDTH-1:0]   rd_data2,
  output logic               err,
  output logic               err_sticky
);
  logic             legal, nonzero;
  logic [WIDTH-1:0] regs [NREGS];
  logic             err_d, err_q, err_sticky_d, err_sticky_q;
  logic             byp1, byp2;
  assign {legal, nonzero} = onehot0_chk(wr_sel);
  for (genvar i = 0; i < NREGS; i++) begin : g_reg
    rf_reg_en #(.WIDTH(WIDTH)) u_reg (
      .clk  (clk),
      .rst_n(rst_n),
      .en   (wr_sel[i] & legal),
      .d    (wr_data),
      .q    (regs[i])
    );
  end
  // illegal selects never forward; a set bit implies nonzero
  always_comb begin
    byp1     = (BYPASS != 0) && legal && nonzero && wr_sel[rd_addr1];
    byp2     = (BYPASS != 0) && legal && nonzero && wr_sel[rd_addr2];
    rd_data1 = byp1 ? wr_data : regs[rd_addr1];
    rd_data2 = byp2 ? wr_data : regs[rd_addr2];
  end
  always_comb begin
    err_d        = ~legal;
    err_sticky_d = err_sticky_q | ~legal;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      err_q        <= 1'b0;
      err_sticky_q <= 1'b0;
    end else begin
      err_q        <= err_d;
      err_sticky_q <= err_sticky_d;
    end
  assign err        = err_q;
  assign err_sticky = err_sticky_q;
endmodule

// File: tb/tb_rf8_onehot_wr.sv
// tb_rf8_onehot_wr: directed scoreboard bench for rf8_onehot_wr, checking a
// bypassing instance and a non-bypassing instance driven in parallel
module tb_rf8_onehot_wr;
  localparam int W = 16;
  typedef struct {
    string       tag;
    int          sig;
    logic [W-1:0] val;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [7:0]   wr_sel;
  logic [W-1:0] wr_data;
  logic [2:0]   rd_addr1, rd_addr2;
  logic [W-1:0] b_rd1, b_rd2, n_rd1, n_rd2;
  logic         b_err, b_sticky, n_err, n_sticky;

  exp_t         sb[$];
  logic [W-1:0] m [8];
  int           n_chk = 0;
  int           n_fail = 0;

  rf8_onehot_wr #(.WIDTH(W), .BYPASS(1)) dut (
    .clk(clk), .rst_n(rst_n), .wr_sel(wr_sel), .wr_data(wr_data),
    .rd_addr1(rd_addr1), .rd_addr2(rd_addr2), .rd_data1(b_rd1), .rd_data2(b_rd2),
    .err(b_err), .err_sticky(b_sticky)
  );
  rf8_onehot_wr #(.WIDTH(W), .BYPASS(0)) dut_nb (
    .clk(clk), .rst_n(rst_n), .wr_sel(wr_sel), .wr_data(wr_data),
    .rd_addr1(rd_addr1), .rd_addr2(rd_addr2), .rd_data1(n_rd1), .rd_data2(n_rd2),
    .err(n_err), .err_sticky(n_sticky)
  );

  always #5 clk = ~clk;

  // sig: 0/1 bypass rd1/rd2, 2/3 non-bypass rd1/rd2, 4 err, 5 err_sticky (both instances)
  function automatic logic [W-1:0] obs(int s);
    case (s)
      0: return b_rd1;
      1: return b_rd2;
      2: return n_rd1;
      3: return n_rd2;
      4: return (b_err === n_err) ? {15'd0, b_err} : 16'hxxxx;
      default: return (b_sticky === n_sticky) ? {15'd0, b_sticky} : 16'hxxxx;
    endcase
  endfunction

  task automatic push(input string tag, input int sig, input logic [W-1:0] val);
    sb.push_back('{tag, sig, val});
  endtask

  task automatic push_rd(input string tag, input logic [W-1:0] b1, input logic [W-1:0] b2,
                         input logic [W-1:0] n1, input logic [W-1:0] n2);
    push({tag, "_b1"}, 0, b1);
    push({tag, "_b2"}, 1, b2);
    push({tag, "_n1"}, 2, n1);
    push({tag, "_n2"}, 3, n2);
  endtask

  task automatic push_err(input string tag, input logic e, input logic s);
    push({tag, "_err"}, 4, {15'd0, e});
    push({tag, "_sticky"}, 5, {15'd0, s});
  endtask

  task automatic drain();
    exp_t e;
    logic [W-1:0] o;
    #2;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      o = obs(e.sig);
      n_chk++;
      assert (o === e.val) else begin
        n_fail++;
        $error("FAIL %s: observed %h expected %h", e.tag, o, e.val);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int i, input logic [W-1:0] d);
    wr_sel  = 8'd1 << i;
    wr_data = d;
    tick();
    m[i]   = d;
    wr_sel = 8'd0;
  endtask

  initial begin
    rst_n = 1'b0; wr_sel = 8'd0; wr_data = '0; rd_addr1 = 3'd0; rd_addr2 = 3'd7;
    for (int i = 0; i < 8; i++) m[i] = '0;
    #3;
    push_rd("rst_init", 16'h0, 16'h0, 16'h0, 16'h0);
    push_err("rst_init", 1'b0, 1'b0);
    drain();
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // single write, visible next cycle without bypass
    rd_addr1 = 3'd5; rd_addr2 = 3'd4;
    wr_sel = 8'b0010_0000; wr_data = 16'h1234;
    push_rd("wr5_same", 16'h1234, m[4], m[5], m[4]);
    drain();
    tick();
    m[5] = 16'h1234; wr_sel = 8'd0;
    push_rd("wr5_next", 16'h1234, m[4], 16'h1234, m[4]);
    drain();
    for (int j = 0; j < 8; j++) begin
      rd_addr1 = 3'(j); rd_addr2 = 3'(7 - j);
      push_rd($sformatf("wr5_all%0d", j), m[j], m[7-j], m[j], m[7-j]);
      drain();
    end

    // bypass on both ports to the same register
    wr(2, 16'h00AA);
    rd_addr1 = 3'd2; rd_addr2 = 3'd2;
    wr_sel = 8'b0000_0100; wr_data = 16'h5555;
    push_rd("byp_same", 16'h5555, 16'h5555, 16'h00AA, 16'h00AA);
    push_err("byp_same", 1'b0, 1'b0);
    drain();
    tick();
    m[2] = 16'h5555; wr_sel = 8'd0;
    push_rd("byp_after", 16'h5555, 16'h5555, 16'h5555, 16'h5555);
    drain();

    // illegal select: no write, no bypass, err pulse, sticky set
    wr(0, 16'h0A0A);
    wr(7, 16'h7070);
    rd_addr1 = 3'd0; rd_addr2 = 3'd7;
    wr_sel = 8'b1000_0001; wr_data = 16'hFFFF;
    push_rd("ill_same", 16'h0A0A, 16'h7070, 16'h0A0A, 16'h7070);
    push_err("ill_same", 1'b0, 1'b0);
    drain();
    tick();
    wr_sel = 8'd0;
    push_rd("ill_after", 16'h0A0A, 16'h7070, 16'h0A0A, 16'h7070);
    push_err("ill_after", 1'b1, 1'b1);
    drain();
    tick();
    push_err("ill_clr", 1'b0, 1'b1);
    drain();
    wr_sel = 8'b0000_0110;
    tick();
    push_err("b2b_1", 1'b1, 1'b1);
    drain();
    wr_sel = 8'b1111_1111;
    tick();
    wr_sel = 8'd0;
    push_err("b2b_2", 1'b1, 1'b1);
    push_rd("b2b_hold", 16'h0A0A, 16'h7070, 16'h0A0A, 16'h7070);
    drain();
    for (int k = 0; k < 10; k++) begin
      tick();
      push_err($sformatf("sticky%0d", k), 1'b0, 1'b1);
      drain();
    end

    // full sweep then idle cycles
    for (int i = 0; i < 8; i++) wr(i, 16'h1000 + 16'(i));
    wr_sel = 8'd0;
    repeat (3) tick();
    for (int j = 0; j < 8; j++) begin
      rd_addr1 = 3'(j); rd_addr2 = 3'(j);
      push_rd($sformatf("sweep%0d", j), 16'h1000 + 16'(j), 16'h1000 + 16'(j),
              16'h1000 + 16'(j), 16'h1000 + 16'(j));
      drain();
    end

    // asynchronous reset mid-cycle clears state without a clock edge
    wr(3, 16'hBEEF);
    rd_addr1 = 3'd3; rd_addr2 = 3'd3;
    push_rd("pre_rst", 16'hBEEF, 16'hBEEF, 16'hBEEF, 16'hBEEF);
    drain();
    rst_n = 1'b0;
    for (int i = 0; i < 8; i++) m[i] = '0;
    push_rd("async_rst", 16'h0, 16'h0, 16'h0, 16'h0);
    push_err("async_rst", 1'b0, 1'b0);
    drain();
    wr_sel = 8'b0000_1000; wr_data = 16'h7777;
    push_rd("rst_byp", 16'h7777, 16'h7777, 16'h0, 16'h0);
    drain();
    tick();
    wr_sel = 8'd0;
    push_rd("rst_nowr", 16'h0, 16'h0, 16'h0, 16'h0);
    drain();
    rst_n = 1'b1;
    tick();
    push_err("post_rst", 1'b0, 1'b0);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
